regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, at least 2; AW = $clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2: read-port count, 1 to 4.
REQ-004 SHALL have parameter NWR, default 2: write-port count, 1 to 3.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rd_addr, input, NRD*AW bits: read address; port i occupies slice [i*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*XLEN bits: read data, same slicing as rd_addr.
REQ-010 SHALL have port rd_busy, output, NRD bits: 1 means a write to the addressed register is still pending.
REQ-011 SHALL have port wr_en, input, NWR bits: write-enable for each write port.
REQ-012 SHALL have port wr_addr, input, NWR*AW bits: write address for each write port.
REQ-013 SHALL have port wr_data, input, NWR*XLEN bits: write data for each write port.
REQ-014 SHALL have port sb_set, input, 1 bit: marks register sb_addr as pending a write (issue).
REQ-015 SHALL have port sb_addr, input, AW bits: scoreboard set address.

Function
REQ-016 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be busy.
REQ-017 Reads SHALL be combinational from rd_addr, with zero-cycle latency.
REQ-018 A write with wr_en[j]=1 and a nonzero address SHALL update the register at the next rising edge of clk.
REQ-019 When several ports write the same address in one cycle, the highest-index port SHALL win, and the other writes to that address SHALL be discarded.
REQ-020 When BYPASS=1, a read whose address matches an enabled nonzero write in the same cycle SHALL return that write's wr_data; the REQ-019 winner SHALL be used when several ports match.
REQ-021 When BYPASS=0, such a read SHALL return the old register contents.
REQ-022 Each register except register 0 SHALL hold a busy bit, and the busy state SHALL be registered.
REQ-023 sb_set=1 with a nonzero sb_addr SHALL set that register's busy bit at the next rising edge.
REQ-024 Any enabled write to a register SHALL clear its busy bit at the next rising edge.
REQ-025 When sb_set and a write target the same register in the same cycle, the set SHALL win: the busy bit is 1 afterwards and the data is still written.
REQ-026 rd_busy[i] SHALL equal busy[rd_addr_i], except that it SHALL be 0 when BYPASS=1 and a same-cycle enabled write targets rd_addr_i.
REQ-027 Unused upper address values, when NREG is less than 2^AW, SHALL NOT occur because NREG is a power of two; no out-of-range handling is required.

Reset
REQ-028 While rst=1 at a rising edge, all registers SHALL become 0 and all busy bits SHALL become 0.
REQ-029 While rst=1, wr_en and sb_set SHALL be ignored, and reset SHALL take priority over any same-cycle write or set.
REQ-030 While rst=1, bypass SHALL be suppressed, and rd_data SHALL reflect array contents, which are 0 from the first reset edge onward.
REQ-031 After rst is released, the first rising edge SHALL accept writes and sets normally.

Structure
REQ-032 Package regfile_pkg SHALL hold the default constants (XLEN, NREG, NRD, NWR) and a function returning AW.
REQ-033 Sub-module regfile_wr_sel SHALL compute, for a given address, a hit flag plus the winning data.
REQ-034 regfile_wr_sel SHALL perform its selection using the highest-index-wins priority of REQ-019.
REQ-035 regfile_wr_sel SHALL be instantiated once per register for the write path and once per read port for the bypass path.
REQ-036 Register storage SHALL be a flop array with no inferred RAM, because multi-write-port storage is required.

Verification
REQ-037 Reset: write 0xDEADBEEF to r5, then assert rst for one cycle -> the r5 read gives 0 and rd_busy=0.
REQ-038 x0: wr_en[0]=1, wr_addr=0, wr_data=0xFFFFFFFF, and sb_set on address 0 -> r0 reads 0 and its busy bit stays 0.
REQ-039 Write collision: ports 0 and 1 both write r7, port 0 with 0x11 and port 1 with 0x22 -> after the edge r7 = 0x22; with BYPASS=1 the same-cycle read of r7 = 0x22.
REQ-040 Bypass mode: r3 = 0xA, then write 0xB to r3 while reading r3 in the same cycle -> BYPASS=1 returns 0xB and BYPASS=0 returns 0xA; the next cycle returns 0xB in both cases.
REQ-041 Scoreboard: sb_set r9 -> rd_busy=1 the next cycle; write r9=0x5 two cycles later -> rd_busy=0 in the write cycle (BYPASS=1) and after the edge.
REQ-042 Set/clear race: sb_set r4 and write r4=0x7 in the same cycle -> r4=0x7 with busy=1, then a later write clears busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the multi-port register file.
// No logic here; latency/backpressure not applicable.
package regfile_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int NRD_D  = 2;
  localparam int NWR_D  = 2;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction
endpackage

// File: rtl/regfile_wr_sel.sv
// Write-port match for one address: hit flag plus data of the highest-index matching port.
// Combinational, zero latency; no backpressure.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int AW   = 5,
  parameter int NWR  = NWR_D
) (
  input  logic [AW-1:0]       i_addr,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic                o_hit,
  output logic [XLEN-1:0]     o_data
);

  // Ascending scan: a later (higher-index) match overrides earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr) && (i_addr != '0)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and optional write bypass.
// Reads combinational (0 cycles), writes/sets land at next edge; no backpressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREG   = NREG_D,
  parameter int NRD    = NRD_D,
  parameter int NWR    = NWR_D,
  parameter int BYPASS = 1,
  localparam int AW    = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  logic [XLEN-1:0] w_rf [NREG];
  logic [NREG-1:0] w_busy;

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    if (k == 0) begin : g_zero
      assign w_rf[k]   = '0;
      assign w_busy[k] = 1'b0;
    end else begin : g_live
      logic            w_hit;
      logic [XLEN-1:0] w_wdat;
      logic [XLEN-1:0] r_q;
      logic            r_b;

      regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
        .i_addr    (AW'(k)),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_hit     (w_hit),
        .o_data    (w_wdat)
      );

      // Issue-time set beats a same-cycle completing write on the busy bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
          r_b <= 1'b0;
        end else begin
          if (w_hit) r_q <= w_wdat;
          if (sb_set && (sb_addr == AW'(k))) r_b <= 1'b1;
          else if (w_hit)                    r_b <= 1'b0;
        end
      end

      assign w_rf[k]   = r_q;
      assign w_busy[k] = r_b;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic            w_hit;
    logic [XLEN-1:0] w_bdat;
    logic            w_byp;

    assign w_ra = rd_addr[i*AW +: AW];

    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .i_addr    (w_ra),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_hit     (w_hit),
      .o_data    (w_bdat)
    );

    // Forwarding is off during reset so reads show the array being cleared.
    assign w_byp                   = (BYPASS != 0) && !rst && w_hit;
    assign rd_data[i*XLEN +: XLEN] = w_byp ? w_bdat : w_rf[w_ra];
    assign rd_busy[i]              = w_byp ? 1'b0 : w_busy[w_ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypass and a non-bypass regfile_mp with identical stimulus and
// compares both against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]      rd_busy_a, rd_busy_b;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  logic [XLEN-1:0] mreg  [NREG];
  bit              mbusy [NREG];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Highest-numbered enabled port aimed at a nonzero address is the one that counts.
  function automatic bit model_wr(input int a, output logic [XLEN-1:0] d);
    d = '0;
    if (a == 0) return 1'b0;
    for (int j = NWR - 1; j >= 0; j--) begin
      if (wr_en[j] && (int'(wr_addr[j*AW +: AW]) == a)) begin
        d = wr_data[j*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_check();
    logic [XLEN-1:0] d;
    bit              h;
    int              a;
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      h = model_wr(a, d) && !rst;
      chk("byp_data", rd_data_a[i*XLEN +: XLEN], h ? d : mreg[a]);
      chk("byp_busy", {31'd0, rd_busy_a[i]}, {31'd0, h ? 1'b0 : mbusy[a]});
      chk("nob_data", rd_data_b[i*XLEN +: XLEN], mreg[a]);
      chk("nob_busy", {31'd0, rd_busy_b[i]}, {31'd0, mbusy[a]});
    end
  endtask

  task automatic model_update();
    logic [XLEN-1:0] d;
    bit              h;
    for (int k = 0; k < NREG; k++) begin
      if (rst) begin
        mreg[k]  = '0;
        mbusy[k] = 1'b0;
      end else if (k != 0) begin
        h = model_wr(k, d);
        if (h) mreg[k] = d;
        if (sb_set && int'(sb_addr) == k) mbusy[k] = 1'b1;
        else if (h)                       mbusy[k] = 1'b0;
      end
    end
  endtask

  // Inputs change at negedge; outputs sampled 1 ns later; model advances at posedge.
  task automatic cycle();
    #1;
    if (chk_on) model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    for (int k = 0; k < NREG; k++) begin
      mreg[k]  = '0;
      mbusy[k] = 1'b0;
    end
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    @(negedge clk);
    cycle();
    chk_on = 1'b1;
    set_rd(0, 5); set_rd(1, 31);
    cycle();
    rst = 1'b0;

    // Reset clears a written register and has priority over same-cycle write/set.
    set_wr(0, 5, 32'hDEADBEEF);
    cycle();
    idle();
    peek();
    chk("r5_written", rd_data_a[0 +: XLEN], 32'hDEADBEEF);
    cycle();
    rst = 1'b1;
    set_wr(1, 5, 32'h12345678);
    sb_set = 1'b1; sb_addr = 5'd5;
    cycle();
    rst = 1'b0;
    idle();
    peek();
    chk("r5_reset_data", rd_data_a[0 +: XLEN], 32'h0);
    chk("r5_reset_busy", {31'd0, rd_busy_a[0]}, 32'h0);
    cycle();

    // Register 0 ignores writes and scoreboard sets.
    set_wr(0, 0, 32'hFFFFFFFF);
    sb_set = 1'b1; sb_addr = 5'd0;
    set_rd(0, 0);
    peek();
    chk("x0_same_data", rd_data_a[0 +: XLEN], 32'h0);
    cycle();
    idle();
    peek();
    chk("x0_data", rd_data_a[0 +: XLEN], 32'h0);
    chk("x0_busy", {31'd0, rd_busy_a[0]}, 32'h0);
    cycle();

    // Two ports collide on r7; port 1 wins.
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    set_rd(0, 7);
    peek();
    chk("coll_bypass", rd_data_a[0 +: XLEN], 32'h22);
    cycle();
    idle();
    peek();
    chk("coll_a", rd_data_a[0 +: XLEN], 32'h22);
    chk("coll_b", rd_data_b[0 +: XLEN], 32'h22);
    cycle();

    // Bypass on vs off.
    set_wr(0, 3, 32'hA);
    cycle();
    idle();
    set_wr(1, 3, 32'hB);
    set_rd(0, 3);
    peek();
    chk("byp_on", rd_data_a[0 +: XLEN], 32'hB);
    chk("byp_off", rd_data_b[0 +: XLEN], 32'hA);
    cycle();
    idle();
    peek();
    chk("byp_next_a", rd_data_a[0 +: XLEN], 32'hB);
    chk("byp_next_b", rd_data_b[0 +: XLEN], 32'hB);
    cycle();

    // Scoreboard set then clear by a later write.
    sb_set = 1'b1; sb_addr = 5'd9;
    set_rd(1, 9);
    cycle();
    idle();
    peek();
    chk("sb_busy_set", {31'd0, rd_busy_a[1]}, 32'h1);
    cycle();
    set_wr(0, 9, 32'h5);
    peek();
    chk("sb_busy_byp", {31'd0, rd_busy_a[1]}, 32'h0);
    chk("sb_busy_nob", {31'd0, rd_busy_b[1]}, 32'h1);
    cycle();
    idle();
    peek();
    chk("sb_clr_a", {31'd0, rd_busy_a[1]}, 32'h0);
    chk("sb_clr_b", {31'd0, rd_busy_b[1]}, 32'h0);
    chk("sb_data", rd_data_a[XLEN +: XLEN], 32'h5);
    cycle();

    // Set and write to the same register in one cycle: set wins, data lands.
    sb_set = 1'b1; sb_addr = 5'd4;
    set_wr(0, 4, 32'h7);
    cycle();
    idle();
    set_rd(0, 4);
    peek();
    chk("race_data", rd_data_b[0 +: XLEN], 32'h7);
    chk("race_busy", {31'd0, rd_busy_b[0]}, 32'h1);
    cycle();
    set_wr(1, 4, 32'h8);
    cycle();
    idle();
    peek();
    chk("race_clr", {31'd0, rd_busy_a[0]}, 32'h0);
    chk("race_data2", rd_data_a[0 +: XLEN], 32'h8);
    cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = (n % 4 == 0) ? 31 : 11;
      rst     = ($urandom_range(0, 39) == 0);
      wr_en   = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW]     = AW'($urandom_range(0, hi));
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, hi));
      sb_set  = $urandom_range(0, 2) == 0;
      sb_addr = AW'($urandom_range(0, hi));
      cycle();
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
